krom_fetch: RTL
===============

Name: krom_fetch

Overview:
- Read-side controller for the 64x32 SHA-256 K-constant ROM macro (sky130 OpenROM, registered address, data valid after the falling edge).
- On `start`, issues the 64 ROM reads K[0..63] in order and captures each word on the correct edge.
- Delivers the words to the round engine as a valid/ready stream, with a small prefetch buffer to absorb backpressure.
- Sits between the ROM macro and the compression-round FSM.

Parameters:
- `ROUNDS`, 64, number of K words fetched per run (1..2^ADDR_W).
- `ADDR_W`, 6, ROM address width.
- `DATA_W`, 32, ROM word width.
- `DEPTH`, 3, prefetch FIFO entries. Minimum 2; 3 or more needed for 1 word/cycle.

Ports:
- `clk` in 1: system clock; also drives ROM `clk0`.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a run. Single-cycle pulse; sampled only in IDLE.
- `abort` in 1: synchronous flush and return to IDLE. Has priority over `start`.
- `rom_cs` out 1: ROM chip select, active high. Drives `cs0`.
- `rom_addr` out ADDR_W: ROM address. Drives `addr0`.
- `rom_dout` in DATA_W: ROM data. Driven from `dout0`.
- `k_valid` out 1: stream data valid.
- `k_ready` in 1: round engine ready.
- `k_data` out DATA_W: K[t].
- `k_index` out ADDR_W: t of the current `k_data`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; all outputs 0; FIFO empty; issue counter 0; pending flag 0.
- FSM states:
  - IDLE: `start` -> FETCH; clear issue counter and pop counter.
  - FETCH: issue reads; move to DRAIN once `ROUNDS` reads have been issued.
  - DRAIN: no issues. When the pop counter reaches `ROUNDS` -> IDLE, with `done`=1 for exactly that one cycle and `busy` dropping to 0 at the same time.
- Issue rule (FETCH only):
  - `rom_cs`=1 when (fifo_count + pend) < DEPTH. Registered output.
  - `rom_addr` = issue counter; counter increments per issue.
  - When `rom_cs`=0, `rom_addr` holds its last value (no toggling).
- Capture timing:
  - A read issued in cycle N is sampled by the ROM at edge E(N+1), which sets `pend`.
  - At edge E(N+2), `rom_dout` is pushed into the FIFO.
  - `rom_dout` is never sampled at any other edge; the ROM drives X between reads.
- Latency: `start` sampled at E0 -> `rom_cs` high for addr 0 after E0 -> `k_valid`=1 after E2.
- Throughput: with `k_ready`=1 and DEPTH>=3, one word per cycle, so 64 consecutive beats.
- Stream protocol:
  - A handshake occurs when `k_valid` and `k_ready` are both 1.
  - While `k_valid`=1 and `k_ready`=0, `k_data` and `k_index` stay stable.
  - `k_valid` never drops without a handshake, except on `abort` or reset.
  - `k_index` counts 0..ROUNDS-1 and follows the FIFO head.
- Push and pop in the same cycle: both take effect; the FIFO never overflows because the credit rule counts `pend`.
- `abort` in any state: next cycle is IDLE, FIFO empty, `k_valid`=0, `busy`=0, no `done`. An in-flight `pend` word is discarded: `pend` is cleared and the edge-E(N+2) capture is suppressed.
- `start` while `busy`: ignored.
- `start` and `abort` in the same cycle in IDLE: stays IDLE.
- Reset mid-run: immediate asynchronous return to reset values.
- Counters are ADDR_W+1 bits so that `ROUNDS`=2^ADDR_W terminates without wrap.

Decomposition:
- Package `sha256_pkg`:
  - constants `K_WORDS`=64, `K_ADDR_W`=6, `WORD_W`=32;
  - enum `krom_state_t` {IDLE, FETCH, DRAIN};
  - K[0]/K[63] golden constants for benches.
- Sub-module `krom_fetch_fifo`: DEPTH-entry synchronous FIFO with async active-low reset, a `count` output and a `flush` input, carrying {index, data}.

Test Plan:
1. Reset: hold `rst_n`=0 with `start`=1 -> `rom_cs`, `k_valid`, `busy`, `done` all 0. Release -> state stays IDLE with no ROM activity.
2. Full-rate run against the behavioural ROM loaded with k.bin, `k_ready`=1 -> first `k_valid` 2 cycles after `start`, then 64 consecutive beats. Checks: `k_data` 0x428a2f98 at t=0, 0x71374491 at t=1, 0xc67178f2 at t=63; `done` pulses once, 1 cycle after the last beat; exactly 64 `rom_cs` cycles, with addresses 0..63 in order.
3. Backpressure: hold `k_ready`=0 for 10 cycles at t=5 -> `rom_cs` stops with fifo_count+pend=3; `k_data`=K[5] stays stable; on resume, no word is lost or duplicated and `k_index` stays contiguous.
4. Random `k_ready` (50%) over 3 runs -> each run receives the full K sequence; FIFO never overflows; `rom_dout` X values never reach `k_data`.
5. `abort` asserted at t=20 while a read is pending -> next cycle `k_valid`=0, `busy`=0, no `done`. A following `start` delivers K[0]=0x428a2f98 first.
6. `start` pulsed again at t=30 -> ignored, run completes normally. Async `rst_n` at t=40 -> outputs clear immediately, and a subsequent run is correct.

Source files
------------

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Shared constants and types for the SHA-256 K-constant fetch path.
//   K_WORDS / K_ADDR_W / WORD_W : geometry of the K ROM macro.
//   krom_state_t                : sequencing states of krom_fetch.
//   K_FIRST / K_LAST            : golden K[0] and K[63] for quick checks.
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int unsigned K_WORDS  = 64;
    localparam int unsigned K_ADDR_W = 6;
    localparam int unsigned WORD_W   = 32;

    localparam logic [WORD_W-1:0] K_FIRST = 32'h428a2f98;
    localparam logic [WORD_W-1:0] K_LAST  = 32'hc67178f2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } krom_state_t;

endpackage

// File: rtl/krom_fetch_fifo.sv
// ---------------------------------------------------------------------------
// krom_fetch_fifo
//   DEPTH-entry synchronous FIFO used as the prefetch buffer between the ROM
//   capture point and the K stream.
//   clk_i, rst_n_i : clock, async active-low reset
//   flush_i        : synchronous clear, wins over push/pop
//   push_i, data_i : write side
//   pop_i          : read side, head advances when not empty
//   data_o         : current head entry
//   count_o        : number of valid entries
//   empty_o        : no valid entries
// ---------------------------------------------------------------------------
module krom_fetch_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 38
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/krom_fetch.sv
// ---------------------------------------------------------------------------
// krom_fetch
//   Read-side controller for the 64x32 K-constant ROM macro. On start it
//   reads K[0..ROUNDS-1] in order and streams them to the round engine over
//   valid/ready, with a small prefetch FIFO absorbing backpressure.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no run; waits for start (abort wins over start)
//   FETCH | issuing ROM reads while credit allows
//   DRAIN | all reads issued; waits for the last handshake, then done
//
//   clk_i, rst_n_i        : system clock (also ROM clk0), async active-low reset
//   start_i, abort_i      : begin run / synchronous flush to IDLE
//   rom_cs_o, rom_addr_o  : ROM chip select and address (registered)
//   rom_dout_i            : ROM data, valid only two edges after the issue cycle
//   k_valid_o, k_ready_i  : K stream handshake
//   k_data_o, k_index_o   : K[t] and t of the FIFO head
//   busy_o, done_o        : run in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module krom_fetch
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = K_WORDS,
    parameter int unsigned ADDR_W = K_ADDR_W,
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned DEPTH  = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              rom_cs_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_dout_i,
    output logic              k_valid_o,
    input  logic              k_ready_i,
    output logic [DATA_W-1:0] k_data_o,
    output logic [ADDR_W-1:0] k_index_o,
    output logic              busy_o,
    output logic              done_o
);

    // One extra bit so ROUNDS == 2**ADDR_W is reachable without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned FCW   = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = FCW + 2;

    krom_state_t       state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic              rom_cs_q, rom_cs_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              done_q, done_d;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_idx_q;

    logic [FCW-1:0]           fifo_count;
    logic                     fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic                     push, pop;
    logic [SUM_W-1:0]         inflight;
    logic                     credit_ok;

    // pend_q means the ROM sampled an address at the last edge, so rom_dout_i
    // holds that word at this edge and at no other.
    assign push = pend_q & ~abort_i;
    assign pop  = ~fifo_empty & k_ready_i;

    // Everything that will occupy the FIFO after this edge if we issue now:
    // stored words, the word landing now, the read the ROM samples now, minus
    // the word leaving now.
    assign inflight  = SUM_W'(fifo_count) + SUM_W'(pend_q) + SUM_W'(rom_cs_q) - SUM_W'(pop);
    assign credit_ok = (inflight < SUM_W'(DEPTH));

    krom_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (abort_i),
        .push_i  (push),
        .data_i  ({pend_idx_q, rom_dout_i}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = FETCH;
                FETCH:   if (issue_cnt_q == CNT_W'(ROUNDS)) state_d = DRAIN;
                DRAIN:   if (pop_cnt_d == CNT_W'(ROUNDS)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_cs_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q + CNT_W'(pop);
        done_d      = 1'b0;
        if (!abort_i) begin
            case (state_q)
                IDLE: begin
                    // The first read goes out in the same cycle FETCH is entered.
                    if (start_i) begin
                        rom_cs_d    = 1'b1;
                        rom_addr_d  = '0;
                        issue_cnt_d = CNT_W'(1);
                        pop_cnt_d   = '0;
                    end
                end
                FETCH: begin
                    if (issue_cnt_q < CNT_W'(ROUNDS) && credit_ok) begin
                        rom_cs_d    = 1'b1;
                        rom_addr_d  = issue_cnt_q[ADDR_W-1:0];
                        issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (pop_cnt_d == CNT_W'(ROUNDS)) done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
        end else begin
            rom_cs_q    <= rom_cs_d;
            rom_addr_q  <= rom_addr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            done_q      <= done_d;
            pend_q      <= rom_cs_q & ~abort_i;
            if (rom_cs_q) begin
                pend_idx_q <= rom_addr_q;
            end
        end
    end

    assign rom_cs_o   = rom_cs_q;
    assign rom_addr_o = rom_addr_q;
    assign k_valid_o  = ~fifo_empty;
    // Stale FIFO contents are masked so nothing but a live word reaches the engine.
    assign k_data_o   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign k_index_o  = fifo_empty ? '0 : fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

endmodule
